// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// cpu_io_pkg : shared constants and FSM encoding for the CPU output-port UART
// Revision   : 1.0
// ============================================================================
package cpu_io_pkg;

  localparam int c_DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int c_DEFAULT_FIFO_DEPTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO; a push while full is accepted only when a pop
//             happens on the same edge
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int           AW     = $clog2(DEPTH);
  localparam logic [AW:0]  c_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_FULL);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_uart_tx.sv
`default_nettype none
// ============================================================================
// cpu_uart_tx : buffers CPU output-port bytes and sends them as 8N1 UART frames
// Revision    : 1.0
// ============================================================================
module cpu_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = c_DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    dout_data,
  input  logic                          dout_we,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int            CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

  tx_state_t     r_state;
  tx_state_t     w_state_next;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_overflow;
  logic          w_tx_next;
  logic          w_bit_done;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_data;

  assign w_bit_done = (r_bit_cnt == '0);
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign tx         = r_tx;
  assign overflow   = r_overflow;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (dout_we),
    .pop     (w_pop),
    .wr_data (dout_data),
    .rd_data (w_fifo_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_next = ST_START;
      ST_START: if (w_bit_done) w_state_next = ST_DATA;
      ST_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = ST_STOP;
      ST_STOP:  if (w_bit_done) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = r_shift[r_bit_idx];
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Bit timer reloads at every bit boundary; the index wraps 7->0 leaving DATA.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_tx <= w_tx_next;
      if (dout_we && w_full && !w_pop) r_overflow <= 1'b1;
      if (r_state == ST_IDLE) begin
        if (w_pop) begin
          r_shift   <= w_fifo_data;
          r_bit_cnt <= c_BIT_RELOAD;
          r_bit_idx <= '0;
        end
      end else if (w_bit_done) begin
        r_bit_cnt <= c_BIT_RELOAD;
        if (r_state == ST_DATA) r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt - c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_cpu_uart_tx : scoreboard bench; a UART line monitor decodes frames and
//                  compares them with bytes queued at stimulus time
// Revision       : 1.0
// ============================================================================
module tb_cpu_uart_tx;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] dout_data = 8'h00;
  logic       dout_we   = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [3:0] fifo_count;

  int         n_checks    = 0;
  int         n_errors    = 0;
  int         cyc         = 0;
  int         frames_rx   = 0;
  int         peak        = 0;
  bit         tx_low_seen = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  cpu_uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dout_data  (dout_data),
    .dout_we    (dout_we),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (frames_rx < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("frames_received", frames_rx, target);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Writes first, first+1, ... on consecutive edges; w = cycle of the first write edge.
  task automatic write_burst(input logic [7:0] first, input int n, input int n_keep, output int w);
    w = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) w = cyc + 1;
      dout_data = first + 8'(i);
      dout_we   = 1'b1;
      if (i < n_keep) exp_q.push_back(first + 8'(i));
    end
    @(negedge clk);
    dout_we = 1'b0;
  endtask

  // UART line monitor: start detected at the first low sample, bits sampled mid-bit.
  initial begin
    bit         mon_active;
    int         mon_cnt;
    logic [7:0] mon_byte;
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_byte   = 8'h00;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) tx_low_seen = 1'b1;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!rst_n) begin
        mon_active = 1'b0;
        exp_q.delete();
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) begin
          chk("start_bit_mid", int'(tx), 0);
        end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
          mon_byte[(mon_cnt - 6) / 4] = tx;
        end else if (mon_cnt == 38) begin
          chk("stop_bit_mid", int'(tx), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame at cycle %0d", mon_byte, cyc);
          end else begin
            chk("frame_byte", int'(mon_byte), int'(exp_q.pop_front()));
          end
          frames_rx++;
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int s0, s1, s2;
    int rx_before;

    do_reset();
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fifo_count", int'(fifo_count), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Single byte 0xA5 to an idle block
    start_q.delete();
    write_burst(8'hA5, 1, 1, w);
    at_cyc(w + 1);
    chk("t1_tx_before_start", int'(tx), 1);
    chk("t1_busy_after_write", int'(busy), 1);
    at_cyc(w + 2);
    chk("t1_tx_start", int'(tx), 0);
    at_cyc(w + 40);
    chk("t1_busy_in_stop", int'(busy), 1);
    wait_frames(1, 100);
    at_cyc(w + 42);
    chk("t1_busy_done", int'(busy), 0);
    chk("t1_tx_idle", int'(tx), 1);
    chk("t1_start_cycle", (start_q.size() > 0) ? start_q.pop_front() : -1, w + 2);

    // Back-to-back 0x01, 0x02, 0x03
    start_q.delete();
    peak = 0;
    write_burst(8'h01, 3, 3, w);
    wait_frames(4, 3 * 41 + 60);
    chk("t2_fifo_peak_ge2", int'(peak >= 2), 1);
    chk("t2_start_count", start_q.size(), 3);
    if (start_q.size() >= 3) begin
      s0 = start_q.pop_front();
      s1 = start_q.pop_front();
      s2 = start_q.pop_front();
      chk("t2_first_start", s0, w + 2);
      chk("t2_spacing_1", s1 - s0, 41);
      chk("t2_spacing_2", s2 - s1, 41);
    end

    // Overflow: 0x10..0x19, last one dropped
    write_burst(8'h10, 10, 9, w);
    chk("t3_overflow_set", int'(overflow), 1);
    chk("t3_count_full", int'(fifo_count), 8);
    wait_frames(13, 9 * 41 + 80);
    at_cyc(cyc + 5);
    chk("t3_drained_count", int'(fifo_count), 0);
    chk("t3_drained_busy", int'(busy), 0);
    chk("t3_overflow_sticky", int'(overflow), 1);
    do_reset();
    chk("t3_overflow_cleared", int'(overflow), 0);

    // Full FIFO with the pop edge coincident with a write of 0x77
    start_q.delete();
    write_burst(8'h20, 9, 9, w);
    exp_q.push_back(8'h77);
    at_cyc(w + 41);
    chk("t4_count_full", int'(fifo_count), 8);
    chk("t4_overflow_before", int'(overflow), 0);
    @(negedge clk);
    dout_data = 8'h77;
    dout_we   = 1'b1;
    at_cyc(w + 42);
    dout_we = 1'b0;
    chk("t4_count_unchanged", int'(fifo_count), 8);
    chk("t4_overflow_clear", int'(overflow), 0);
    wait_frames(23, 10 * 41 + 80);
    chk("t4_overflow_end", int'(overflow), 0);

    // Reset during DATA bit 3 of 0xFF, then a fresh byte 0x3C
    write_burst(8'hFF, 1, 1, w);
    at_cyc(w + 18);
    chk("t5_busy_mid_frame", int'(busy), 1);
    rst_n = 1'b0;
    at_cyc(w + 19);
    chk("t5_reset_tx", int'(tx), 1);
    chk("t5_reset_count", int'(fifo_count), 0);
    chk("t5_reset_busy", int'(busy), 0);
    at_cyc(w + 21);
    rst_n       = 1'b1;
    tx_low_seen = 1'b0;
    rx_before   = frames_rx;
    at_cyc(w + 100);
    chk("t5_no_frames_after_reset", frames_rx, rx_before);
    chk("t5_tx_stayed_high", int'(tx_low_seen), 0);
    write_burst(8'h3C, 1, 1, w);
    wait_frames(rx_before + 1, 100);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
